// File: rtl/ft600_pkg.sv
// Shared FT600 245-mode definitions: bus widths, responder state encoding and the
// {be, data} word carried through both buffers and the host streams.
package ft600_pkg;

  localparam int unsigned FT_DATA_W = 16;
  localparam int unsigned FT_BE_W   = 2;
  localparam int unsigned FT_WORD_W = FT_BE_W + FT_DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_TURN,
    ST_RD_ACTIVE,
    ST_WR_ACTIVE
  } ft_state_t;

  typedef struct packed {
    logic [FT_BE_W-1:0]   be;
    logic [FT_DATA_W-1:0] data;
  } ft_word_t;

endpackage

// File: rtl/ft_sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy output; a push into a full buffer is
// accepted when a pop happens on the same edge.
module ft_sync_fifo #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];
  assign count   = cnt;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ft600_responder.sv
// FT600 chip-side emulation of the 245 synchronous 16-bit FIFO bus, bridging the
// FPGA bus strobes to host-side injection (h2f) and capture (f2h) streams.
module ft600_responder
  import ft600_pkg::*;
#(
  parameter int unsigned RX_DEPTH = 64,
  parameter int unsigned TX_DEPTH = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [FT_DATA_W-1:0] ft_data_i,
  input  logic [FT_BE_W-1:0]   ft_be_i,
  output logic [FT_DATA_W-1:0] ft_data_o,
  output logic [FT_BE_W-1:0]   ft_be_o,
  output logic                 ft_oe_o,
  output logic                 ft_rxf_n,
  output logic                 ft_txe_n,
  input  logic                 ft_oe_n,
  input  logic                 ft_rd_n,
  input  logic                 ft_wr_n,
  input  logic                 h2f_valid,
  output logic                 h2f_ready,
  input  logic [FT_WORD_W-1:0] h2f_word,
  output logic                 f2h_valid,
  input  logic                 f2h_ready,
  output logic [FT_WORD_W-1:0] f2h_word,
  output logic                 proto_err
);

  localparam int unsigned RX_CW = $clog2(RX_DEPTH) + 1;
  localparam int unsigned TX_CW = $clog2(TX_DEPTH) + 1;

  ft_state_t        state;
  ft_state_t        state_next;
  logic [RX_CW-1:0] rx_count;
  logic [TX_CW-1:0] tx_count;
  ft_word_t         rx_head;
  ft_word_t         tx_head;
  ft_word_t         tx_in;
  logic             rx_full;
  logic             rx_empty;
  logic             tx_full;
  logic             tx_empty;
  logic             conflict;
  logic             rd_beat;
  logic             wr_beat;
  logic             h2f_push;
  logic             f2h_pop;
  logic             err;

  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == RX_CW'(RX_DEPTH));
  assign tx_empty = (tx_count == '0);
  assign tx_full  = (tx_count == TX_CW'(TX_DEPTH));

  // Both OE_N and WR_N low is a bus contention: neither direction moves data.
  assign conflict = !ft_oe_n && !ft_wr_n;
  assign rd_beat  = rst_n && (state == ST_RD_ACTIVE) && !ft_rd_n && !rx_empty && !conflict;
  assign wr_beat  = rst_n && !ft_wr_n && ft_oe_n && !tx_full;

  // A read beat frees a slot on the same edge, so a full buffer can still take a word.
  assign h2f_ready = !rx_full || rd_beat;
  assign h2f_push  = h2f_valid && h2f_ready;
  assign f2h_valid = !tx_empty;
  assign f2h_pop   = f2h_valid && f2h_ready;
  assign f2h_word  = tx_head;

  assign tx_in.be   = ft_be_i;
  assign tx_in.data = ft_data_i;

  assign ft_rxf_n  = rx_empty;
  assign ft_txe_n  = tx_full;
  assign ft_oe_o   = (state == ST_RD_ACTIVE);
  assign ft_data_o = (ft_oe_o && !rx_empty) ? rx_head.data : '0;
  assign ft_be_o   = (ft_oe_o && !rx_empty) ? rx_head.be   : '0;
  assign proto_err = err;

  ft_sync_fifo #(
    .WIDTH (FT_WORD_W),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (h2f_push),
    .push_data (h2f_word),
    .pop       (rd_beat),
    .head      (rx_head),
    .count     (rx_count)
  );

  ft_sync_fifo #(
    .WIDTH (FT_WORD_W),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wr_beat),
    .push_data (tx_in),
    .pop       (f2h_pop),
    .head      (tx_head),
    .count     (tx_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      if (conflict) err <= 1'b1;
    end
  end

  // Bus phase tracking; contention always drops back to IDLE.
  always_comb begin
    state_next = state;
    if (conflict) begin
      state_next = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (!ft_oe_n)      state_next = ST_RD_TURN;
          else if (!ft_wr_n) state_next = ST_WR_ACTIVE;
        end
        ST_RD_TURN:   state_next = ft_oe_n ? ST_IDLE : ST_RD_ACTIVE;
        ST_RD_ACTIVE: if (ft_oe_n) state_next = ST_IDLE;
        ST_WR_ACTIVE: if (ft_wr_n) state_next = ST_IDLE;
        default:      state_next = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ft600_responder.sv
// Directed + randomized bench for ft600_responder against a queue-based model of the
// FT600 bus rules (turnaround, show-ahead reads, backpressure, contention, reset).
module tb_ft600_responder;

  localparam int unsigned RXD = 64;
  localparam int unsigned TXD = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ft_data_i;
  logic [1:0]  ft_be_i;
  logic [15:0] ft_data_o;
  logic [1:0]  ft_be_o;
  logic        ft_oe_o;
  logic        ft_rxf_n;
  logic        ft_txe_n;
  logic        ft_oe_n;
  logic        ft_rd_n;
  logic        ft_wr_n;
  logic        h2f_valid;
  logic        h2f_ready;
  logic [17:0] h2f_word;
  logic        f2h_valid;
  logic        f2h_ready;
  logic [17:0] f2h_word;
  logic        proto_err;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [17:0] rx_q[$];
  logic [17:0] tx_q[$];
  int          oe_cnt = 0;
  bit          m_err = 1'b0;

  always #5 clk = ~clk;

  ft600_responder #(
    .RX_DEPTH (RXD),
    .TX_DEPTH (TXD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ft_data_i (ft_data_i),
    .ft_be_i   (ft_be_i),
    .ft_data_o (ft_data_o),
    .ft_be_o   (ft_be_o),
    .ft_oe_o   (ft_oe_o),
    .ft_rxf_n  (ft_rxf_n),
    .ft_txe_n  (ft_txe_n),
    .ft_oe_n   (ft_oe_n),
    .ft_rd_n   (ft_rd_n),
    .ft_wr_n   (ft_wr_n),
    .h2f_valid (h2f_valid),
    .h2f_ready (h2f_ready),
    .h2f_word  (h2f_word),
    .f2h_valid (f2h_valid),
    .f2h_ready (f2h_ready),
    .f2h_word  (f2h_word),
    .proto_err (proto_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs against the model, take the edge, update the model.
  task automatic tick();
    bit          conflict, rd_b, wr_b, push_b, pop_b, oe_exp;
    logic [17:0] hw, tw, hd;
    #1;
    conflict = !ft_oe_n && !ft_wr_n;
    oe_exp   = (oe_cnt >= 2);
    rd_b     = rst_n && oe_exp && !ft_rd_n && !conflict && (rx_q.size() > 0);
    wr_b     = rst_n && !ft_wr_n && ft_oe_n && (tx_q.size() < TXD);
    push_b   = rst_n && h2f_valid && ((rx_q.size() < RXD) || rd_b);
    pop_b    = rst_n && f2h_ready && (tx_q.size() > 0);
    chk("oe_o", 32'(ft_oe_o), 32'(oe_exp));
    if (!oe_exp) begin
      chk("data_idle", 32'(ft_data_o), 32'h0);
      chk("be_idle", 32'(ft_be_o), 32'h0);
    end else if (rx_q.size() > 0) begin
      hd = rx_q[0];
      chk("rd_data", 32'(ft_data_o), 32'(hd[15:0]));
      chk("rd_be", 32'(ft_be_o), 32'(hd[17:16]));
    end
    chk("h2f_ready", 32'(h2f_ready), 32'((rx_q.size() < RXD) || rd_b));
    chk("f2h_valid", 32'(f2h_valid), 32'(tx_q.size() > 0));
    if (tx_q.size() > 0) chk("f2h_word", 32'(f2h_word), 32'(tx_q[0]));
    hw = h2f_word;
    tw = {ft_be_i, ft_data_i};
    @(posedge clk);
    #1;
    if (!rst_n) begin
      rx_q.delete();
      tx_q.delete();
      oe_cnt = 0;
      m_err  = 1'b0;
    end else begin
      if (rd_b)   void'(rx_q.pop_front());
      if (push_b) rx_q.push_back(hw);
      if (pop_b)  void'(tx_q.pop_front());
      if (wr_b)   tx_q.push_back(tw);
      if (conflict) m_err = 1'b1;
      oe_cnt = (!ft_oe_n && ft_wr_n) ? ((oe_cnt >= 2) ? 2 : oe_cnt + 1) : 0;
    end
    chk("rxf_n", 32'(ft_rxf_n), 32'(rx_q.size() == 0));
    chk("txe_n", 32'(ft_txe_n), 32'(tx_q.size() == TXD));
    chk("proto_err", 32'(proto_err), 32'(m_err));
  endtask

  task automatic inject(input int n);
    for (int i = 0; i < n; i++) begin
      h2f_valid = 1'b1;
      h2f_word  = 18'($urandom);
      tick();
    end
    h2f_valid = 1'b0;
  endtask

  task automatic read_burst(input int n, input bit feed);
    ft_oe_n = 1'b0;
    tick();
    tick();
    ft_rd_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      h2f_valid = feed;
      h2f_word  = 18'($urandom);
      tick();
    end
    h2f_valid = 1'b0;
    ft_rd_n   = 1'b1;
    ft_oe_n   = 1'b1;
    tick();
  endtask

  task automatic write_burst(input int n);
    ft_wr_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      ft_data_i = 16'($urandom);
      ft_be_i   = 2'($urandom);
      tick();
    end
    ft_wr_n = 1'b1;
    tick();
  endtask

  task automatic drain_tx();
    f2h_ready = 1'b1;
    for (int i = 0; i < int'(TXD) + 2 && tx_q.size() > 0; i++) tick();
    f2h_ready = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; ft_data_i = '0; ft_be_i = '0; ft_oe_n = 1'b1; ft_rd_n = 1'b1;
    ft_wr_n = 1'b1; h2f_valid = 1'b0; h2f_word = '0; f2h_ready = 1'b0;
    @(posedge clk);
    tick();
    rst_n = 1'b1;
    chk("rst_rxf_n", 32'(ft_rxf_n), 32'h1);
    chk("rst_txe_n", 32'(ft_txe_n), 32'h0);
    chk("rst_oe_o", 32'(ft_oe_o), 32'h0);
    chk("rst_h2f_ready", 32'(h2f_ready), 32'h1);
    chk("rst_f2h_valid", 32'(f2h_valid), 32'h0);
    chk("rst_proto_err", 32'(proto_err), 32'h0);

    // Three injected words read back in order after the OE turnaround.
    h2f_valid = 1'b1; h2f_word = 18'h31111; tick();
    h2f_word = 18'h32222; tick();
    h2f_word = 18'h33333; tick();
    h2f_valid = 1'b0;
    ft_oe_n = 1'b0; tick();
    chk("turn_oe_o", 32'(ft_oe_o), 32'h0);
    tick();
    chk("beat1_data", 32'(ft_data_o), 32'h1111);
    ft_rd_n = 1'b0; tick();
    chk("beat2_data", 32'(ft_data_o), 32'h2222);
    tick();
    chk("beat3_data", 32'(ft_data_o), 32'h3333);
    tick();
    chk("rxf_after_3", 32'(ft_rxf_n), 32'h1);
    ft_rd_n = 1'b1; ft_oe_n = 1'b1; tick();

    // Two FPGA writes captured with their byte enables.
    ft_wr_n = 1'b0; ft_data_i = 16'hA5A5; ft_be_i = 2'b01; tick();
    ft_data_i = 16'h5A5A; ft_be_i = 2'b11; tick();
    ft_wr_n = 1'b1; tick();
    chk("f2h_first", 32'(f2h_word), 32'h1A5A5);
    f2h_ready = 1'b1; tick();
    chk("f2h_second", 32'(f2h_word), 32'h35A5A);
    tick();
    f2h_ready = 1'b0;
    chk("f2h_empty", 32'(f2h_valid), 32'h0);

    // TX overflow: the last two writes are backpressured, not errors.
    write_burst(int'(TXD) + 2);
    chk("tx_full_txe", 32'(ft_txe_n), 32'h1);
    chk("tx_full_err", 32'(proto_err), 32'h0);
    drain_tx();

    // Randomized mixed traffic.
    for (int r = 0; r < 8; r++) begin
      inject(int'($urandom_range(1, 12)));
      read_burst(int'($urandom_range(0, 14)), 1'($urandom));
      write_burst(int'($urandom_range(1, 10)));
      f2h_ready = 1'($urandom);
      tick();
      drain_tx();
    end
    read_burst(int'(RXD), 1'b0);

    // Full RX with simultaneous inject and read across the pointer wrap.
    inject(int'(RXD) + 1);
    chk("rx_full_ready", 32'(h2f_ready), 32'h0);
    read_burst(70, 1'b1);
    chk("rx_still_full", 32'(h2f_ready), 32'h0);
    read_burst(int'(RXD) + 1, 1'b0);
    chk("rx_drained", 32'(ft_rxf_n), 32'h1);

    // Contention: sticky error, buffers untouched.
    inject(3);
    write_burst(2);
    ft_oe_n = 1'b0; ft_wr_n = 1'b0; ft_rd_n = 1'b0; tick();
    ft_oe_n = 1'b1; ft_wr_n = 1'b1; ft_rd_n = 1'b1; tick();
    chk("conflict_err", 32'(proto_err), 32'h1);
    chk("conflict_rx_kept", 32'(ft_rxf_n), 32'h0);
    read_burst(4, 1'b0);
    drain_tx();
    chk("conflict_sticky", 32'(proto_err), 32'h1);

    // Reset in the middle of a read burst.
    inject(5);
    write_burst(3);
    ft_oe_n = 1'b0; tick(); tick();
    ft_rd_n = 1'b0; tick(); tick();
    rst_n = 1'b0; tick();
    chk("mid_rst_rxf_n", 32'(ft_rxf_n), 32'h1);
    chk("mid_rst_txe_n", 32'(ft_txe_n), 32'h0);
    chk("mid_rst_oe_o", 32'(ft_oe_o), 32'h0);
    chk("mid_rst_data", 32'(ft_data_o), 32'h0);
    chk("mid_rst_be", 32'(ft_be_o), 32'h0);
    chk("mid_rst_h2f_ready", 32'(h2f_ready), 32'h1);
    chk("mid_rst_f2h_valid", 32'(f2h_valid), 32'h0);
    chk("mid_rst_proto_err", 32'(proto_err), 32'h0);
    rst_n = 1'b1; ft_rd_n = 1'b1; ft_oe_n = 1'b1;
    tick();
    inject(2);
    read_burst(3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
